// File: rtl/ard_frame_receiver.sv
// Bit-serial receiver for the Arduino button link. It synchronises the serial
// clock, data and latch into the core clock domain, shifts in one frame
// (MSB first, with a trailing even-parity bit), checks the frame length and
// parity, and then publishes the hall and car button fields.
module ard_frame_receiver #(
    parameter int FLOORS      = 7,
    parameter int NUM_ELEV    = 3,
    parameter int ACCUMULATE  = 0,
    parameter int TIMEOUT_CYC = 50000,
    localparam int FB_W    = 2 * (FLOORS - 1),
    localparam int IB_W    = FLOORS + 2,
    localparam int IBT_W   = NUM_ELEV * IB_W,
    localparam int FRAME_W = FB_W + IBT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_clk,
    input  logic             ser_data,
    input  logic             ser_latch,
    input  logic [FB_W-1:0]  clr_floor_button,
    input  logic [IBT_W-1:0] clr_internal_button,
    output logic [FB_W-1:0]  floor_button,
    output logic [IBT_W-1:0] internal_button,
    output logic             frame_valid,
    output logic             frame_error,
    output logic             busy
);

    localparam int CW = $clog2(FRAME_W + 3);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_W + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FRAME_W + 2);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t           state_q, state_d;
    logic [2:0]       sclk_q, slat_q;
    logic [1:0]       sdat_q;
    logic [FRAME_W:0] shreg;
    logic [CW-1:0]    cnt;
    logic [TW-1:0]    tmo;
    logic             clk_edge, lat_edge;
    logic             do_shift, cnt_one, cnt_clr, tmo_clr, tmo_inc, pub, err;

    // Frame layout: shreg[FRAME_W:1] holds the data bits, shreg[0] the parity.
    logic [FB_W-1:0]  new_fb;
    logic [IBT_W-1:0] new_ib;
    assign new_fb = shreg[FRAME_W -: FB_W];
    assign new_ib = shreg[IBT_W:1];

    assign clk_edge = sclk_q[1] & ~sclk_q[2];
    assign lat_edge = slat_q[1] & ~slat_q[2];
    assign busy     = (state_q == SHIFT);

    // Two-flop synchronisers plus a third stage for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            slat_q <= '0;
            sdat_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], ser_clk};
            slat_q <= {slat_q[1:0], ser_latch};
            sdat_q <= {sdat_q[0], ser_data};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and datapath controls; a bit arriving with the latch is
    // shifted before the frame is checked.
    always_comb begin
        state_d  = state_q;
        do_shift = 1'b0;
        cnt_one  = 1'b0;
        cnt_clr  = 1'b0;
        tmo_clr  = 1'b0;
        tmo_inc  = 1'b0;
        pub      = 1'b0;
        err      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clk_edge) begin
                    do_shift = 1'b1;
                    cnt_one  = 1'b1;
                    tmo_clr  = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (clk_edge) begin
                    do_shift = 1'b1;
                    tmo_clr  = 1'b1;
                end
                if (lat_edge) begin
                    state_d = CHECK;
                end else if (!clk_edge) begin
                    if (tmo == TMO_MAX) begin
                        err     = 1'b1;
                        cnt_clr = 1'b1;
                        tmo_clr = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tmo_inc = 1'b1;
                    end
                end
            end
            CHECK: begin
                if (cnt == CNT_FULL && !(^shreg)) pub = 1'b1;
                else                              err = 1'b1;
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift register, saturating bit counter, timeout counter, status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg       <= '0;
            cnt         <= '0;
            tmo         <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (do_shift) shreg <= {shreg[FRAME_W-1:0], sdat_q[1]};
            if (cnt_one)                          cnt <= CW'(1);
            else if (cnt_clr)                     cnt <= '0;
            else if (do_shift && cnt != CNT_MAX)  cnt <= cnt + CW'(1);
            if (tmo_clr)      tmo <= '0;
            else if (tmo_inc) tmo <= tmo + TW'(1);
            frame_valid <= pub;
            frame_error <= err;
        end
    end

    // Published outputs: replace on a good frame, or OR-accumulate with
    // per-bit clears where a same-cycle set beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            floor_button    <= '0;
            internal_button <= '0;
        end else if (ACCUMULATE != 0) begin
            floor_button    <= (floor_button & ~clr_floor_button)
                             | (pub ? new_fb : '0);
            internal_button <= (internal_button & ~clr_internal_button)
                             | (pub ? new_ib : '0);
        end else if (pub) begin
            floor_button    <= new_fb;
            internal_button <= new_ib;
        end
    end

endmodule

// File: tb/tb_ard_frame_receiver.sv
// Directed bench: one replace-mode receiver and one accumulate-mode receiver
// share the serial lines and clear inputs.
module tb_ard_frame_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ser_clk = 1'b0, ser_data = 1'b0, ser_latch = 1'b0;
    logic [11:0] clr_fb = '0;
    logic [26:0] clr_ib = '0;
    logic [11:0] fb0, fb1;
    logic [26:0] ib0, ib1;
    logic        fv0, fe0, bz0, fv1, fe1, bz1;
    int          checks = 0, errors = 0, both = 0;

    always #5 clk = ~clk;

    ard_frame_receiver #(.FLOORS(7), .NUM_ELEV(3), .ACCUMULATE(0), .TIMEOUT_CYC(100)) dut0 (
        .clk(clk), .rst_n(rst_n), .ser_clk(ser_clk), .ser_data(ser_data),
        .ser_latch(ser_latch), .clr_floor_button(clr_fb), .clr_internal_button(clr_ib),
        .floor_button(fb0), .internal_button(ib0), .frame_valid(fv0),
        .frame_error(fe0), .busy(bz0));

    ard_frame_receiver #(.FLOORS(7), .NUM_ELEV(3), .ACCUMULATE(1), .TIMEOUT_CYC(100)) dut1 (
        .clk(clk), .rst_n(rst_n), .ser_clk(ser_clk), .ser_data(ser_data),
        .ser_latch(ser_latch), .clr_floor_button(clr_fb), .clr_internal_button(clr_ib),
        .floor_button(fb1), .internal_button(ib1), .frame_valid(fv1),
        .frame_error(fe1), .busy(bz1));

    // frame_valid and frame_error must never coincide.
    always @(negedge clk) if ((fv0 && fe0) || (fv1 && fe1)) both++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] mk(input logic [38:0] d);
        return {d, ^d};
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk) ser_data = b;
        @(negedge clk) ser_clk = 1'b1;
        repeat (3) @(negedge clk);
        ser_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_bits(input logic [39:0] f, input int n);
        for (int i = 39; i > 39 - n; i--) send_bit(f[i]);
    endtask

    // Raise the latch and watch six cycles for status pulses on dut0.
    task automatic send_latch(output int nv, output int ne, output int vpos);
        nv = 0; ne = 0; vpos = 0;
        @(negedge clk) ser_latch = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (fv0) begin nv++; vpos = i; end
            if (fe0) ne++;
        end
        ser_latch = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int nv, ne, vp, nfe;
        logic [39:0] fa, fbad, fb2;
        fa   = mk(39'h5A_5A5A_5A5A);
        fbad = fa ^ 40'h1;
        fb2  = mk(39'h12_3456_789A);

        repeat (3) @(negedge clk);
        chk("rst_fb", fb0, 12'h000);
        chk("rst_ib", ib0, 27'h0);
        chk("rst_busy", bz0, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Good frame: floor is data[38:27], cars data[26:0].
        send_bits(fa, 40);
        chk("shift_busy", bz0, 1'b1);
        send_latch(nv, ne, vp);
        chk("good_nv", nv, 1);
        chk("good_vpos", vp, 4);
        chk("good_ne", ne, 0);
        chk("good_fb", fb0, 12'hB4B);
        chk("good_ib", ib0, 27'h25A5A5A);
        chk("good_idle", bz0, 1'b0);

        // Bad parity: error, outputs held.
        send_bits(fbad, 40);
        send_latch(nv, ne, vp);
        chk("par_ne", ne, 1);
        chk("par_nv", nv, 0);
        chk("par_fb", fb0, 12'hB4B);
        chk("par_ib", ib0, 27'h25A5A5A);

        // Short frame.
        send_bits(fb2, 39);
        send_latch(nv, ne, vp);
        chk("short_ne", ne, 1);
        chk("short_fb", fb0, 12'hB4B);

        // Long frame (counter saturates).
        send_bits(fb2, 40);
        send_bit(1'b0);
        send_latch(nv, ne, vp);
        chk("long_ne", ne, 1);
        chk("long_nv", nv, 0);

        // Good frame after the errors.
        send_bits(fb2, 40);
        send_latch(nv, ne, vp);
        chk("rec_nv", nv, 1);
        chk("rec_fb", fb0, 12'h246);
        chk("rec_ib", ib0, 27'h456789A);

        // Timeout mid-frame.
        send_bits(fa, 20);
        chk("to_busy", bz0, 1'b1);
        nfe = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fe0) nfe++;
        end
        chk("to_ne", nfe, 1);
        chk("to_busy_fall", bz0, 1'b0);
        chk("to_fb", fb0, 12'h246);
        send_bits(fa, 40);
        send_latch(nv, ne, vp);
        chk("to_rec_nv", nv, 1);
        chk("to_rec_fb", fb0, 12'hB4B);

        // Reset at bit 17 of a frame.
        send_bits(fb2, 17);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("mrst_fb", fb0, 12'h000);
        chk("mrst_ib", ib0, 27'h0);
        chk("mrst_busy", bz0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_bits(fb2, 40);
        send_latch(nv, ne, vp);
        chk("mrst_nv", nv, 1);
        chk("mrst_fb2", fb0, 12'h246);
        chk("mrst_ib2", ib0, 27'h456789A);

        // Accumulate mode.
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_bits(mk(39'h1 << 27), 40);
        send_latch(nv, ne, vp);
        send_bits(mk(39'h1 << 30), 40);
        send_latch(nv, ne, vp);
        chk("acc_or", fb1, 12'h009);
        chk("rep_fb", fb0, 12'h008);
        @(negedge clk) clr_fb = 12'h001;
        @(negedge clk) clr_fb = 12'h000;
        chk("acc_clr", fb1, 12'h008);
        chk("rep_noclr", fb0, 12'h008);
        // Clear bit 3 exactly on the cycle a good frame sets it again.
        send_bits(mk(39'h1 << 30), 40);
        @(negedge clk) ser_latch = 1'b1;
        repeat (3) @(negedge clk);
        clr_fb = 12'h008;
        @(negedge clk) clr_fb = 12'h000;
        chk("acc_setwins_fv", fv1, 1'b1);
        chk("acc_setwins", fb1, 12'h008);
        ser_latch = 1'b0;
        repeat (3) @(negedge clk);
        chk("acc_ib", ib1, 27'h0);

        chk("excl", both, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
